if_id_stage: RTL and testbench

IF_ID_STAGE -- requirements
Module: if_id_stage

---
 rtl/mips_pkg.sv | 9 +
 rtl/pc_incrementer.sv | 9 +
 rtl/if_id_stage.sv | 66 ++++++
 tb/tb_if_id_stage.sv | 124 ++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// mips_pkg: shared constants, state encoding and counter width for the IF/ID pipeline register.
package mips_pkg;
  localparam logic [31:0] NOP = 32'h0000_0000;
  localparam logic [31:0] PC_INC = 32'd4;
  localparam int CNT_W = 8;
  typedef logic [CNT_W-1:0] cnt_t;
  localparam cnt_t CNT_MAX = '1;
  typedef enum logic [1:0] {EMPTY, FULL, HELD} ifid_state_e;
endpackage

// File: rtl/pc_incrementer.sv
// pc_incrementer: combinational pc + 4, wrapping modulo 2^32.
module pc_incrementer
  import mips_pkg::*;
(
  input  logic [31:0] pc_i,
  output logic [31:0] pc_plus4_o
);
  assign pc_plus4_o = pc_i + PC_INC;
endmodule

// File: rtl/if_id_stage.sv
// if_id_stage: IF/ID pipeline register with hold, flush-to-bubble and a saturating stall counter.
// Define MIPS_BRANCH_DELAY_SLOT_EN to delay the flush by one fetch so the delay-slot instruction survives.
module if_id_stage
  import mips_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_in,
  input  logic [31:0] instr_in,
  input  logic        hold,
  input  logic        flush,
  output logic [31:0] pc_plus4_out,
  output logic [31:0] instr_out,
  output logic        valid_out,
  output cnt_t        stall_cnt
);
  ifid_state_e state_q, state_d;
  logic [31:0] instr_q, instr_d, pc4_q, pc4_d, pc4;
  cnt_t cnt_q, cnt_d;
  logic eff_flush;
  pc_incrementer u_inc (.pc_i(pc_in), .pc_plus4_o(pc4));
`ifdef MIPS_BRANCH_DELAY_SLOT_EN
  logic pend_q, pend_d;
  // A pending squash waits out any hold so it lands on the first edge that actually advances.
  assign eff_flush = pend_q && !hold;
  assign pend_d = hold ? (pend_q || flush) : flush;
  always_ff @(posedge clk)
    if (rst) pend_q <= 1'b0;
    else pend_q <= pend_d;
`else
  assign eff_flush = flush;
`endif
  always_comb begin
    state_d = state_q;
    instr_d = instr_q;
    pc4_d = pc4_q;
    cnt_d = cnt_q;
    if (eff_flush) begin
      state_d = EMPTY;
      instr_d = NOP;
    end else if (hold) begin
      state_d = (state_q == FULL) ? HELD : state_q;
      cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + cnt_t'(1);
    end else begin
      state_d = FULL;
      instr_d = instr_in;
      pc4_d = pc4;
    end
  end
  always_ff @(posedge clk)
    if (rst) begin
      state_q <= EMPTY;
      instr_q <= NOP;
      pc4_q <= '0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
      pc4_q <= pc4_d;
      cnt_q <= cnt_d;
    end
  assign instr_out = instr_q;
  assign pc_plus4_out = pc4_q;
  assign valid_out = (state_q != EMPTY);
  assign stall_cnt = cnt_q;
endmodule

// File: tb/tb_if_id_stage.sv
// tb_if_id_stage: scoreboard bench with directed scenarios and randomized traffic against a behavioural model.
module tb_if_id_stage;
  logic clk = 1'b0;
  logic rst, hold, flush;
  logic [31:0] pc_in, instr_in, pc_plus4_out, instr_out;
  logic valid_out;
  logic [7:0] stall_cnt;
  int errors = 0;
  int checks = 0;
  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc4;
    logic        valid;
    logic [7:0]  cnt;
  } exp_t;
  exp_t q[$];
  exp_t m;
  logic m_pend;
  if_id_stage dut (
    .clk(clk), .rst(rst), .pc_in(pc_in), .instr_in(instr_in), .hold(hold), .flush(flush),
    .pc_plus4_out(pc_plus4_out), .instr_out(instr_out), .valid_out(valid_out), .stall_cnt(stall_cnt)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  always @(negedge clk)
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk("sb_instr", instr_out, e.instr);
      chk("sb_pc4", pc_plus4_out, e.pc4);
      chk("sb_valid", {31'b0, valid_out}, {31'b0, e.valid});
      chk("sb_cnt", {24'b0, stall_cnt}, {24'b0, e.cnt});
    end
  // Reference: what each edge does to the visible pipeline register, in priority order.
  task automatic step(input logic r, input logic h, input logic f, input logic [31:0] pc, input logic [31:0] ins);
    logic ef;
    rst = r; hold = h; flush = f; pc_in = pc; instr_in = ins;
`ifdef MIPS_BRANCH_DELAY_SLOT_EN
    ef = m_pend && !h;
`else
    ef = f;
`endif
    if (r) begin
      m = '0;
      m_pend = 1'b0;
    end else begin
      if (ef) begin
        m.instr = 32'h0;
        m.valid = 1'b0;
      end else if (h) begin
        if (m.cnt != 8'hFF) m.cnt = m.cnt + 8'd1;
      end else begin
        m.instr = ins;
        m.pc4 = pc + 32'd4;
        m.valid = 1'b1;
      end
      m_pend = h ? (m_pend | f) : f;
    end
    @(posedge clk);
    q.push_back(m);
    #1;
  endtask
  initial begin
    m = '0;
    m_pend = 1'b0;
    step(1, 0, 0, 32'h0, 32'h0);
    chk("reset_valid", {31'b0, valid_out}, 32'h0);
    step(0, 0, 0, 32'h0000_0040, 32'h2008_0005);
    chk("load_instr", instr_out, 32'h2008_0005);
    chk("load_pc4", pc_plus4_out, 32'h0000_0044);
    chk("load_valid", {31'b0, valid_out}, 32'h1);
    repeat (3) step(0, 1, 0, 32'h0000_0044, 32'hDEAD_BEEF);
    chk("hold_instr", instr_out, 32'h2008_0005);
    chk("hold_pc4", pc_plus4_out, 32'h0000_0044);
    chk("hold_cnt", {24'b0, stall_cnt}, 32'd3);
    step(0, 0, 0, 32'h0000_0044, 32'hDEAD_BEEF);
    chk("release_instr", instr_out, 32'hDEAD_BEEF);
    chk("release_pc4", pc_plus4_out, 32'h0000_0048);
`ifndef MIPS_BRANCH_DELAY_SLOT_EN
    step(0, 1, 1, 32'h0000_0048, 32'h1234_5678);
    chk("flushhold_instr", instr_out, 32'h0);
    chk("flushhold_valid", {31'b0, valid_out}, 32'h0);
    chk("flushhold_cnt", {24'b0, stall_cnt}, 32'd3);
    chk("flushhold_pc4", pc_plus4_out, 32'h0000_0048);
`else
    step(0, 0, 1, 32'h0000_0100, 32'h0000_1111);
    chk("ds_slot_instr", instr_out, 32'h0000_1111);
    chk("ds_slot_valid", {31'b0, valid_out}, 32'h1);
    step(0, 0, 0, 32'h0000_0104, 32'h0000_2222);
    chk("ds_squash_valid", {31'b0, valid_out}, 32'h0);
    chk("ds_squash_instr", instr_out, 32'h0);
`endif
    step(0, 0, 0, 32'hFFFF_FFFC, 32'hAAAA_5555);
    chk("wrap_pc4", pc_plus4_out, 32'h0);
    repeat (300) step(0, 1, 0, 32'h0, 32'h0);
    chk("sat_cnt", {24'b0, stall_cnt}, 32'hFF);
    step(1, 0, 0, 32'h0, 32'h0);
    step(0, 0, 0, 32'h0000_0200, 32'h0BAD_F00D);
    repeat (10) step(0, 1, 0, 32'h0, 32'h0);
    chk("midstall_cnt", {24'b0, stall_cnt}, 32'd10);
    step(1, 1, 0, 32'h0, 32'h0);
    chk("rst_instr", instr_out, 32'h0);
    chk("rst_pc4", pc_plus4_out, 32'h0);
    chk("rst_valid", {31'b0, valid_out}, 32'h0);
    chk("rst_cnt", {24'b0, stall_cnt}, 32'h0);
    for (int i = 0; i < 600; i++)
      step($urandom_range(31) == 0, $urandom_range(3) == 0, $urandom_range(5) == 0,
           {$urandom_range(32'h3FFF_FFFF), 2'b00}, $urandom);
    repeat (4) @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
